// File: rtl/noc_link_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_tx_pkg
// Purpose  : Shared definitions for the NoC link transmitter: position of the
//            flit valid bit and the transmitter state encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package noc_link_tx_pkg;

    // Bit 0 of every flit is the valid flag; the downstream FIFO write is
    // gated by this bit.
    localparam int unsigned c_flit_valid_bit = 0;

    // Transmitter state encodings
    typedef enum logic [1:0] {
        TX_INIT  = 2'd0,
        TX_RUN   = 2'd1,
        TX_STALL = 2'd2
    } tx_state_t;

endpackage : noc_link_tx_pkg
`default_nettype wire

// File: rtl/noc_link_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_tx_if
// Purpose  : Bundles the local-FIFO pop interface and the downstream link of
//            the NoC link transmitter.
// Signals  : src_empty     local FIFO empty flag
//            src_data      local FIFO head flit (valid while src_empty=0)
//            src_read      pop strobe for the local FIFO
//            link_data     registered flit toward the downstream FIFO
//            credit_return one pulse per downstream FIFO pop
// Modports : master - transmitter side, slave - environment side
// Revision : 1.0 - initial release
// ============================================================================
interface noc_link_tx_if #(
    parameter int WIDTH = 16
);
    import noc_link_tx_pkg::*;

    logic             src_empty;
    logic [WIDTH-1:0] src_data;
    logic             src_read;
    logic [WIDTH-1:0] link_data;
    logic             credit_return;

    modport master (
        input  src_empty,
        input  src_data,
        input  credit_return,
        output src_read,
        output link_data
    );

    modport slave (
        output src_empty,
        output src_data,
        output credit_return,
        input  src_read,
        input  link_data
    );

endinterface : noc_link_tx_if
`default_nettype wire

// File: rtl/noc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : noc_credit_counter
// Purpose  : Credit arithmetic for the link transmitter. Counts free slots in
//            the downstream FIFO, saturating at MAXC; a return while already
//            full (and not consumed the same cycle) sets a sticky error.
// Ports    : clk          rising-edge clock
//            reset        synchronous, active-high; count <= MAXC
//            inc          one credit returned this cycle
//            dec          one credit consumed this cycle (only when count!=0)
//            count        current credit count
//            count_next   value count takes at the next edge
//            zero         count == 0
//            full         count == MAXC
//            overflow_err sticky: inc while full with no dec
// Revision : 1.0 - initial release
// ============================================================================
module noc_credit_counter
    import noc_link_tx_pkg::*;
#(
    parameter int MAXC = 8,
    parameter int W    = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         inc,
    input  wire logic         dec,
    output logic     [W-1:0]  count,
    output logic     [W-1:0]  count_next,
    output logic              zero,
    output logic              full,
    output logic              overflow_err
);

    localparam logic [W-1:0] c_max = W'(MAXC);

    logic [W-1:0] r_count;
    logic         r_err;
    logic [W-1:0] w_next;
    logic         w_err_set;

    // Simultaneous inc and dec cancel out, so only the one-sided cases move
    // the count. Saturation at both ends keeps the count inside 0..MAXC even
    // if a caller misbehaves.
    always_comb begin
        w_next    = r_count;
        w_err_set = 1'b0;
        if (inc && !dec) begin
            if (r_count == c_max) begin
                w_err_set = 1'b1;
            end else begin
                w_next = r_count + 1'b1;
            end
        end else if (dec && !inc) begin
            if (r_count != '0) begin
                w_next = r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= c_max;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_next;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign count        = r_count;
    assign count_next   = w_next;
    assign zero         = (r_count == '0);
    assign full         = (r_count == c_max);
    assign overflow_err = r_err;

endmodule : noc_credit_counter
`default_nettype wire

// File: rtl/noc_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_tx
// Purpose  : Transmit end of a router-to-router NoC link. Pops flits from the
//            local output FIFO and drives them, registered, onto the link
//            toward the downstream input FIFO under credit-based flow control.
//            Flits with bit[0]=0 at the FIFO head are popped and discarded.
// Ports    : clk        rising-edge clock
//            reset      synchronous, active-high
//            enable     1 = transmission permitted, 0 = hold (no pops)
//            lnk        noc_link_tx_if.master (src_empty, src_data, src_read,
//                       link_data, credit_return)
//            credits    current credit count
//            busy       credits below the initial credit count
//            err_credit sticky: credit returned while credits were full
//            tx_count   number of flits sent
// Config   : NOC_TX_STATS_EN - when defined, tx_count is a wrapping 32-bit
//            send counter; otherwise tx_count is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module noc_link_tx
    import noc_link_tx_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ADDWIDTH = 3,
    parameter int CREDITS  = 8
) (
    input  wire logic                clk,
    input  wire logic                reset,
    input  wire logic                enable,
    noc_link_tx_if.master            lnk,
    output logic     [ADDWIDTH:0]    credits,
    output logic                     busy,
    output logic                     err_credit,
    output logic     [31:0]          tx_count
);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic               w_send;
    logic               w_drop;
    logic               w_head_valid;
    logic               w_pop_ok;
    logic [ADDWIDTH:0]  w_credits_next;
    logic               w_credit_zero;
    logic               w_credit_full;
    logic [WIDTH-1:0]   r_link_data;

    assign w_head_valid = lnk.src_data[c_flit_valid_bit];

    // ------------------------------------------------------------------
    // Credit arithmetic
    // ------------------------------------------------------------------
    noc_credit_counter #(
        .MAXC (CREDITS),
        .W    (ADDWIDTH + 1)
    ) u_credit (
        .clk          (clk),
        .reset        (reset),
        .inc          (lnk.credit_return),
        .dec          (w_send),
        .count        (credits),
        .count_next   (w_credits_next),
        .zero         (w_credit_zero),
        .full         (w_credit_full),
        .overflow_err (err_credit)
    );

    assign busy = ~w_credit_full;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= TX_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and pop decisions
    // ------------------------------------------------------------------
    // Reset is folded into the pop qualifier so src_read is low for the
    // whole time reset is held, even when the registered state is RUN.
    // Stall entry/exit looks at the post-update credit count so the FSM
    // and the counter change together on the same edge.
    always_comb begin
        w_state_next = r_state;
        w_pop_ok     = 1'b0;
        w_send       = 1'b0;
        w_drop       = 1'b0;

        case (r_state)
            TX_INIT: begin
                w_state_next = TX_RUN;
            end
            TX_RUN: begin
                w_pop_ok = enable & ~lnk.src_empty & ~reset;
                w_send   = w_pop_ok & w_head_valid & ~w_credit_zero;
                w_drop   = w_pop_ok & ~w_head_valid;
                if (w_credits_next == '0) begin
                    w_state_next = TX_STALL;
                end
            end
            TX_STALL: begin
                if (w_credits_next != '0) begin
                    w_state_next = TX_RUN;
                end
            end
            default: begin
                w_state_next = TX_INIT;
            end
        endcase
    end

    assign lnk.src_read = w_send | w_drop;

    // ------------------------------------------------------------------
    // Link register: exactly one cycle from pop to link, zero when idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_link_data <= '0;
        end else if (w_send) begin
            r_link_data <= lnk.src_data;
        end else begin
            r_link_data <= '0;
        end
    end

    assign lnk.link_data = r_link_data;

    // ------------------------------------------------------------------
    // Optional send statistics
    // ------------------------------------------------------------------
`ifdef NOC_TX_STATS_EN
    logic [31:0] r_tx_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_count <= 32'd0;
        end else if (w_send) begin
            r_tx_count <= r_tx_count + 32'd1;
        end
    end

    assign tx_count = r_tx_count;
`else
    assign tx_count = 32'd0;
`endif

endmodule : noc_link_tx
`default_nettype wire

// File: tb/tb_noc_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_link_tx
// Purpose  : Self-checking bench for noc_link_tx. A queue models the local
//            FIFO; every valid flit queued is also pushed to an expected
//            queue that a negedge monitor pops whenever a flit appears on
//            the link. Directed checks cover credits, stall, drop, enable,
//            credit overflow error and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_link_tx;

`ifdef NOC_TX_STATS_EN
    localparam bit c_stats = 1'b1;
`else
    localparam bit c_stats = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  credits;
    logic        busy;
    logic        err_credit;
    logic [31:0] tx_count;

    noc_link_tx_if #(.WIDTH(16)) lnk ();

    noc_link_tx #(
        .WIDTH    (16),
        .ADDWIDTH (3),
        .CREDITS  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .lnk        (lnk),
        .credits    (credits),
        .busy       (busy),
        .err_credit (err_credit),
        .tx_count   (tx_count)
    );

    always #5 clk = ~clk;

    logic [15:0] src_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    int          checks = 0;
    int          errors = 0;
    logic        pop_flag = 1'b0;

    // Remember whether the DUT popped on this edge; the model FIFO is
    // updated one delta-safe step later.
    always @(posedge clk) pop_flag <= lnk.src_read;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_tx(input int n);
        return c_stats ? 32'(n) : 32'd0;
    endfunction

    task automatic drive_src();
        lnk.src_empty = (src_q.size() == 0);
        lnk.src_data  = (src_q.size() != 0) ? src_q[0] : 16'h0000;
    endtask

    task automatic push(input logic [15:0] f);
        src_q.push_back(f);
        if (f[0]) exp_q.push_back(f);
        drive_src();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_flag) void'(src_q.pop_front());
        drive_src();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (lnk.link_data[0] === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: unexpected flit %0h, required none", lnk.link_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard_flit", 32'(lnk.link_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lnk.src_empty     = 1'b1;
        lnk.src_data      = 16'h0000;
        lnk.credit_return = 1'b0;
        reset  = 1'b1;
        enable = 1'b1;
        step();
        step();
        check("reset_credits", 32'(credits), 32'd8);
        check("reset_link", 32'(lnk.link_data), 32'd0);
        check("reset_err", 32'(err_credit), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_tx", tx_count, 32'd0);

        // Test 1: three valid flits
        push(16'h0011);
        push(16'h0023);
        push(16'h0035);
        #1;
        check("src_read_in_reset", 32'(lnk.src_read), 32'd0);
        reset = 1'b0;
        #1;
        check("src_read_in_init", 32'(lnk.src_read), 32'd0);
        step();
        check("src_read_run", 32'(lnk.src_read), 32'd1);
        check("link_before_first", 32'(lnk.link_data), 32'd0);
        step();
        check("link_flit1", 32'(lnk.link_data), 32'h0011);
        check("credits_7", 32'(credits), 32'd7);
        step();
        check("link_flit2", 32'(lnk.link_data), 32'h0023);
        step();
        check("link_flit3", 32'(lnk.link_data), 32'h0035);
        check("credits_5", 32'(credits), 32'd5);
        check("busy_1", 32'(busy), 32'd1);
        check("tx_3", tx_count, exp_tx(3));
        check("src_empty_t1", 32'(src_q.size()), 32'd0);

        // Test 3: send and return on the same edge
        push(16'h0047);
        step();
        check("credits_4", 32'(credits), 32'd4);
        check("link_0047", 32'(lnk.link_data), 32'h0047);
        push(16'h0059);
        lnk.credit_return = 1'b1;
        step();
        lnk.credit_return = 1'b0;
        check("credits_send_ret", 32'(credits), 32'd4);
        check("link_0059", 32'(lnk.link_data), 32'h0059);

        // Refill to full, then Test 5: overflow return
        lnk.credit_return = 1'b1;
        repeat (4) step();
        check("credits_refill", 32'(credits), 32'd8);
        check("busy_0", 32'(busy), 32'd0);
        check("err_before", 32'(err_credit), 32'd0);
        step();
        lnk.credit_return = 1'b0;
        check("credits_sat", 32'(credits), 32'd8);
        check("err_set", 32'(err_credit), 32'd1);
        step();
        check("err_sticky", 32'(err_credit), 32'd1);

        // Test 4: invalid head flit is dropped
        push(16'h0010);
        #1;
        check("src_read_drop", 32'(lnk.src_read), 32'd1);
        step();
        check("link_drop", 32'(lnk.link_data), 32'd0);
        check("credits_drop", 32'(credits), 32'd8);
        check("src_empty_drop", 32'(src_q.size()), 32'd0);
        check("tx_drop", tx_count, exp_tx(5));

        // Test 2: ten flits, eight credits
        for (int i = 0; i < 10; i++) push(16'h0101 + 16'(i * 2));
        repeat (8) step();
        check("credits_0", 32'(credits), 32'd0);
        check("link_flit8", 32'(lnk.link_data), 32'h010F);
        check("queue_2", 32'(src_q.size()), 32'd2);
        step();
        check("src_read_stall", 32'(lnk.src_read), 32'd0);
        check("link_stall", 32'(lnk.link_data), 32'd0);
        step();
        check("credits_stall", 32'(credits), 32'd0);
        lnk.credit_return = 1'b1;
        step();
        lnk.credit_return = 1'b0;
        check("credits_1", 32'(credits), 32'd1);
        check("src_read_resume", 32'(lnk.src_read), 32'd1);
        check("link_resume0", 32'(lnk.link_data), 32'd0);
        step();
        check("link_flit9", 32'(lnk.link_data), 32'h0111);
        check("credits_0b", 32'(credits), 32'd0);
        step();
        check("src_read_stall2", 32'(lnk.src_read), 32'd0);

        // Test 6: enable low holds pops, credits still counted
        enable = 1'b0;
        lnk.credit_return = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("src_read_disabled", 32'(lnk.src_read), 32'd0);
            check("link_disabled", 32'(lnk.link_data), 32'd0);
        end
        lnk.credit_return = 1'b0;
        check("credits_disabled", 32'(credits), 32'd5);
        check("queue_disabled", 32'(src_q.size()), 32'd1);
        enable = 1'b1;
        step();
        check("link_0113", 32'(lnk.link_data), 32'h0113);
        check("credits_4b", 32'(credits), 32'd4);

        // Reset in the middle of a stream
        push(16'h0201);
        push(16'h0203);
        push(16'h0205);
        step();
        check("link_0201", 32'(lnk.link_data), 32'h0201);
        check("credits_3", 32'(credits), 32'd3);
        reset = 1'b1;
        #1;
        check("src_read_reset", 32'(lnk.src_read), 32'd0);
        step();
        check("link_after_reset", 32'(lnk.link_data), 32'd0);
        check("credits_after_reset", 32'(credits), 32'd8);
        check("tx_after_reset", tx_count, 32'd0);
        check("err_after_reset", 32'(err_credit), 32'd0);
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 6; i++) push(16'h0301 + 16'(i * 2));
        repeat (8) step();
        check("tx_8", tx_count, exp_tx(8));
        check("credits_final", 32'(credits), 32'd0);
        check("link_030B", 32'(lnk.link_data), 32'h030B);
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_noc_link_tx
`default_nettype wire
